// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//
// Takes one assembly-level request per handshake and validates it against the
// ISA field rules. A legal request is packed into a 16-bit instruction word and
// queued with a sequential program address for the instruction-memory loader.
// This is the write-side counterpart of the 16-bit instruction decoder.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   request handshake; in_ready = FIFO not full
//   in_op                 opcode in decoder format {instr[15:12], instr[7:4]}
//   in_rdest, in_rsrc     register fields
//   in_imm                immediate (range-checked per instruction class)
//   in_cond               Jcond condition code
//   addr_load, addr_in    overwrite the program address counter
//   out_valid / out_ready FIFO head handshake
//   out_data, out_addr    encoded word and its program address at the head
//   err, err_op           sticky illegal-request flag and first offending op
//   count                 FIFO occupancy
// -----------------------------------------------------------------------------
module instr_encoder #(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 16,
    parameter int BASE_ADDR = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_op,
    input  logic [3:0]               in_rdest,
    input  logic [3:0]               in_rsrc,
    input  logic [15:0]              in_imm,
    input  logic [3:0]               in_cond,
    input  logic                     addr_load,
    input  logic [ADDR_W-1:0]        addr_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              out_data,
    output logic [ADDR_W-1:0]        out_addr,
    output logic                     err,
    output logic [7:0]               err_op,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } entry_t;

    // ------------------------------------------------------------------
    // Request decode / encode
    // ------------------------------------------------------------------
    logic [3:0]  op_hi;
    logic [3:0]  op_lo;
    logic        req_legal;
    logic [15:0] req_word;

    assign op_hi = in_op[7:4];
    assign op_lo = in_op[3:0];

    always_comb begin
        req_legal = 1'b0;
        req_word  = 16'h0000;
        case (op_hi)
            4'h0: begin
                // R-type ALU ops; A, C, D, E are holes in the opcode map
                case (op_lo)
                    4'hA, 4'hC, 4'hD, 4'hE: req_legal = 1'b0;
                    default: begin
                        req_legal = 1'b1;
                        req_word  = {op_hi, in_rdest, op_lo, in_rsrc};
                    end
                endcase
            end
            4'h8: begin
                if (op_lo[3:2] == 2'b01) begin
                    // 0x84..0x87 are register-form shifts (R-type)
                    req_legal = 1'b1;
                    req_word  = {op_hi, in_rdest, op_lo, in_rsrc};
                end else begin
                    // Shift-immediate: op[0] is a don't-care, op[3:1]
                    // selects direction/kind, amount is a 4-bit unsigned
                    case (op_lo[3:1])
                        3'b000, 3'b001, 3'b100, 3'b101: begin
                            req_legal = (in_imm[15:4] == 12'h000);
                            req_word  = {4'h8, in_rdest, op_lo[3:1], 1'b0,
                                         in_imm[3:0]};
                        end
                        default: req_legal = 1'b0;
                    endcase
                end
            end
            4'h4: begin
                case (op_lo)
                    4'h0, 4'h4, 4'h8: begin   // LOAD / STOR / JALR
                        req_legal = 1'b1;
                        req_word  = {4'h4, in_rdest, op_lo, in_rsrc};
                    end
                    4'hC: begin               // Jcond: cond sits in Rdest slot
                        req_legal = (in_cond != 4'hF);
                        req_word  = {4'h4, in_cond, 4'hC, in_rsrc};
                    end
                    default: req_legal = 1'b0;
                endcase
            end
            4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7,
            4'h9, 4'hA, 4'hB, 4'hC: begin
                // 8-bit immediate must be a sign-extended value
                req_legal = (in_imm[15:8] == {8{in_imm[7]}});
                req_word  = {op_hi, in_rdest, in_imm[7:0]};
            end
            default: req_legal = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    entry_t [DEPTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               err_q, err_d;
    logic [7:0]         err_op_q, err_op_d;

    logic               accept;
    logic               push;
    logic               pop;
    logic [ADDR_W-1:0]  cur_addr;

    assign in_ready = (count_q < CNT_W'(DEPTH));
    assign accept   = in_valid && in_ready;
    assign push     = accept && req_legal;
    assign pop      = out_valid && out_ready;

    // A load in the same cycle as an enqueue applies to that word
    assign cur_addr = addr_load ? addr_in : pc_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pc_d     = pc_q;
        err_d    = err_q;
        err_op_d = err_op_q;

        if (push) begin
            mem_d[wr_ptr_q].addr = cur_addr;
            mem_d[wr_ptr_q].data = req_word;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
            pc_d                 = cur_addr + ADDR_W'(1);
        end else if (addr_load) begin
            pc_d = addr_in;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (accept && !req_legal) begin
            err_d = 1'b1;
            if (!err_q) begin
                err_op_d = in_op;
            end
        end
    end

    // Storage is reset too so the head reads as zero after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            pc_q     <= ADDR_W'(BASE_ADDR);
            err_q    <= 1'b0;
            err_op_q <= 8'h00;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            pc_q     <= pc_d;
            err_q    <= err_d;
            err_op_q <= err_op_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[rd_ptr_q].data;
    assign out_addr  = mem_q[rd_ptr_q].addr;
    assign err       = err_q;
    assign err_op    = err_op_q;
    assign count     = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
//
// Directed stimulus for instr_encoder. The stimulus side pushes the expected
// {addr, word} of every legal request into a queue. A separate monitor pops
// and compares each word the DUT hands over on out_valid && out_ready.
// -----------------------------------------------------------------------------
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_op;
    logic [3:0]  in_rdest;
    logic [3:0]  in_rsrc;
    logic [15:0] in_imm;
    logic [3:0]  in_cond;
    logic        addr_load;
    logic [15:0] addr_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [15:0] out_addr;
    logic        err;
    logic [7:0]  err_op;
    logic [2:0]  count;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    instr_encoder #(.DEPTH(4), .ADDR_W(16), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rdest(in_rdest), .in_rsrc(in_rsrc),
        .in_imm(in_imm), .in_cond(in_cond),
        .addr_load(addr_load), .addr_in(addr_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr),
        .err(err), .err_op(err_op), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: inputs only change at posedge+1, so the negedge value is
    // what the DUT sees at the next rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", {out_addr, out_data}, 32'hxxxxxxxx);
                end else begin
                    chk("scoreboard", {out_addr, out_data}, exp_q.pop_front());
                end
            end
        end
    end

    // One request; waits (bounded) for in_ready, then holds for one edge
    task automatic send(input logic [7:0] op, input logic [3:0] rd,
                        input logic [3:0] rs, input logic [15:0] imm,
                        input logic [3:0] cond, input logic ld,
                        input logic [15:0] ld_addr, input logic legal,
                        input logic [15:0] ew, input logic [15:0] ea);
        int n = 0;
        in_valid = 1'b1; in_op = op; in_rdest = rd; in_rsrc = rs;
        in_imm = imm; in_cond = cond; addr_load = ld; addr_in = ld_addr;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        end else begin
            if (legal) exp_q.push_back({ea, ew});
            @(posedge clk); #1;
        end
        in_valid = 1'b0; addr_load = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, exp_q.size(), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rdest = '0;
        in_rsrc = '0; in_imm = '0; in_cond = '0; addr_load = 1'b0;
        addr_in = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {out_valid, in_ready, err, err_op, count, out_data},
            {1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 16'h0000});
        chk("reset_addr", {16'h0, out_addr}, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // T1: ADD / ADDI, latency and simultaneous push+pop
        out_ready = 1'b1;
        send(8'h05, 4'd3, 4'd4, 16'h0000, 4'h0, 0, 16'h0, 1, 16'h0354, 16'h0000);
        chk("latency", {out_valid, out_addr, out_data}, {1'b1, 16'h0000, 16'h0354});
        send(8'h50, 4'd2, 4'd0, 16'hFFFD, 4'h0, 0, 16'h0, 1, 16'h52FD, 16'h0001);
        chk("push_pop_count", {29'd0, count}, 32'd1);

        // T2: shifts, Jcond, JALR, register-form shift, STOR, CMPI boundary
        send(8'h80, 4'd1, 4'd0, 16'h0005, 4'h0, 0, 16'h0, 1, 16'h8105, 16'h0002);
        send(8'h82, 4'd1, 4'd0, 16'h0005, 4'h0, 0, 16'h0, 1, 16'h8125, 16'h0003);
        send(8'h4C, 4'd0, 4'd7, 16'h0000, 4'hE, 0, 16'h0, 1, 16'h4EC7, 16'h0004);
        send(8'h48, 4'd6, 4'd2, 16'h0000, 4'h0, 0, 16'h0, 1, 16'h4682, 16'h0005);
        send(8'h86, 4'd1, 4'd2, 16'h0000, 4'h0, 0, 16'h0, 1, 16'h8162, 16'h0006);
        send(8'h44, 4'd3, 4'd9, 16'h0000, 4'h0, 0, 16'h0, 1, 16'h4349, 16'h0007);
        send(8'hB0, 4'd5, 4'd0, 16'hFF80, 4'h0, 0, 16'h0, 1, 16'hB580, 16'h0008);
        drain("drain_t2");
        chk("no_err_yet", {31'd0, err}, 32'd0);

        // T3: illegal requests; first one fixes err_op
        send(8'h50, 4'd2, 4'd0, 16'h0100, 4'h0, 0, 16'h0, 0, 16'h0, 16'h0);
        chk("err_first", {23'd0, err, err_op}, {23'd0, 1'b1, 8'h50});
        send(8'h4C, 4'd0, 4'd7, 16'h0000, 4'hF, 0, 16'h0, 0, 16'h0, 16'h0);
        send(8'hD0, 4'd1, 4'd1, 16'h0000, 4'h0, 0, 16'h0, 0, 16'h0, 16'h0);
        send(8'h80, 4'd1, 4'd0, 16'h0010, 4'h0, 0, 16'h0, 0, 16'h0, 16'h0);
        send(8'h0A, 4'd1, 4'd1, 16'h0000, 4'h0, 0, 16'h0, 0, 16'h0, 16'h0);
        chk("err_sticky", {20'd0, err, err_op, count}, {20'd0, 1'b1, 8'h50, 3'd0});
        send(8'h05, 4'd1, 4'd2, 16'h0000, 4'h0, 0, 16'h0, 1, 16'h0152, 16'h0009);
        drain("drain_t3");

        // T4: backpressure with five requests into a 4-deep FIFO
        out_ready = 1'b0;
        fork
            begin
                for (int i = 1; i <= 5; i++)
                    send(8'h05, 4'(i), 4'd0, 16'h0, 4'h0, 0, 16'h0, 1,
                         {4'h0, 4'(i), 8'h50}, 16'(9 + i));
            end
            begin
                repeat (6) @(posedge clk);
                #2;
                chk("full_state", {28'd0, in_ready, count}, {28'd0, 1'b0, 3'd4});
                out_ready = 1'b1;
            end
        join
        drain("drain_t4");

        // T5: address load coincident with enqueue, then wrap
        send(8'h05, 4'd9, 4'd9, 16'h0, 4'h0, 1, 16'hFFFF, 1, 16'h0959, 16'hFFFF);
        send(8'h09, 4'd1, 4'd1, 16'h0, 4'h0, 0, 16'h0, 1, 16'h0191, 16'h0000);
        drain("drain_t5");

        // T6: asynchronous reset with queued words and err set
        out_ready = 1'b0;
        for (int i = 1; i <= 3; i++)
            send(8'h01, 4'(i), 4'd0, 16'h0, 4'h0, 0, 16'h0, 1,
                 {4'h0, 4'(i), 8'h10}, 16'(i));
        chk("pre_reset", {28'd0, err, count}, {28'd0, 1'b1, 3'd3});
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", {out_valid, in_ready, err, err_op, count, out_data},
            {1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 16'h0000});
        chk("async_reset_addr", {16'h0, out_addr}, 32'h0);
        exp_q.delete();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(8'h05, 4'd3, 4'd4, 16'h0000, 4'h0, 0, 16'h0, 1, 16'h0354, 16'h0000);
        drain("drain_t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential instruction encoder and program emitter: the write-side counterpart of the 16-bit instruction decoder. Accepts one assembly-level request per handshake (ALU opcode, register fields, immediate, condition), validates it against the ISA field rules, packs it into the 16-bit instruction word and queues it with a sequential program address for the instruction-memory loader. Sits between the host/boot loader and instruction memory.

## Interface
Parameters:
- DEPTH, 4: output FIFO entries (power of two, ≥2)
- ADDR_W, 16: program address width
- BASE_ADDR, 0: address counter reset value

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_op  in  8  opcode in decoder format: op[7:4]=instr[15:12], op[3:0]=instr[7:4]
- in_rdest  in  4  Rdest field
- in_rsrc  in  4  Rsrc / target register field
- in_imm  in  16  immediate
- in_cond  in  4  Jcond condition code
- addr_load  in  1  load address counter from addr_in
- addr_in  in  ADDR_W  new program address
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer takes head when out_valid && out_ready
- out_data  out  16  encoded instruction at head
- out_addr  out  ADDR_W  program address of head
- err  out  1  sticky: an illegal request was accepted
- err_op  out  8  in_op of first illegal request
- count  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- Encoding of accepted request (class decided by in_op, casex-style):
  - R-type: op[7:4]=0000 with op[3:0] ∈ {0,1,2,3,4,5,6,7,8,9,B,F}, or op ∈ {0x84..0x87}: word = {op[7:4], rdest, op[3:0], rsrc}.
  - 8-bit I-type: op[7:4] ∈ {1,2,3,5,6,7,9,A,B,C}: word = {op[7:4], rdest, imm[7:0]}; legal only if imm[15:8] == {8{imm[7]}}.
  - Shift-immediate: op[7:4]=1000, op[3:1] ∈ {000,001,100,101}: word = {4'h8, rdest, op[3:1], 1'b0, imm[3:0]}; legal only if imm[15:4]==0.
  - LOAD 0x40 / STOR 0x44 / JALR 0x48: word = {4'h4, rdest, op[3:0], rsrc}.
  - Jcond 0x4C: word = {4'h4, cond, 4'hC, rsrc}; legal only if cond ≤ 4'hE.
  - Any other op, or failed range check: illegal.
- Illegal request: still handshaken (consumes in_ready), nothing enqueued, address counter unchanged, err set; err_op captured only on first error.
- Address counter: each enqueued word gets current counter, counter += 1, wraps 2^ADDR_W−1 → 0.
- addr_load: counter ← addr_in; if same cycle as an enqueue, enqueued word takes addr_in and counter ← addr_in+1.
- FIFO: circular, DEPTH entries of {addr, data}; head presented combinationally from storage.
- err/err_op clear only on reset.

## Timing
- Reset (async assert, sync-to-clk effect on deassert): FIFO empty, count=0, out_valid=0, out_data=0, out_addr=0, in_ready=1, err=0, err_op=0, counter=BASE_ADDR.
- in_ready = (count < DEPTH); no pass-through when full, even with out_ready=1.
- Latency: request accepted at edge N → out_valid=1 with word after edge N (visible in cycle N+1) if FIFO was empty.
- Throughput one word/cycle; simultaneous push and pop: count unchanged, order preserved.
- Pop on empty ignored; out_data/out_addr don't-care-stable when out_valid=0.
- err asserts cycle after the illegal handshake.
- Reset mid-stream discards all queued words and error state.

## Test plan
- ADD r3,r4 (op 0x05, rdest 3, rsrc 4), out_ready=1 → next cycle out_data=0x0354, out_addr=0x0000; then ADDI r2,imm 0xFFFD (op 0x50) → 0x52FD at addr 0x0001.
- LSHI r1,5 (op 0x80) → 0x8105; RSHI r1,5 (op 0x82) → 0x8125; Jcond UNC r7 (op 0x4C, cond E) → 0x4EC7; JALR r6,r2 → 0x4682.
- ADDI imm 0x0100, then Jcond cond F, then op 0xD0 → no words enqueued, err=1, err_op=0x50, counter unchanged.
- out_ready=0, five back-to-back valid requests, DEPTH=4 → four accepted, in_ready=0, count=4; raise out_ready → words drain in order, fifth accepted once count<4.
- addr_load with addr_in=0xFFFF coincident with enqueue → word at 0xFFFF, next word at 0x0000.
- Fill 3 entries with err=1, assert rst_n=0 mid-cycle → outputs immediately return to reset values; next request lands at BASE_ADDR.
